lm32_tlb_maint: RTL

LM32_TLB_MAINT -- requirements
Module: lm32_tlb_maint

---
 rtl/lm32_tlb_maint_pkg.sv | 28 ++
 rtl/lm32_tlb_maint.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lm32_tlb_maint_pkg.sv
// Shared encodings for the LM32 TLB maintenance engine: command ops, FSM states
// and the bit positions of the ITLB/DTLB target select.
package lm32_tlb_maint_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_FLUSH  = 2'b01,
        OP_INVAL  = 2'b10,
        OP_UPDATE = 2'b11
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_FLUSH = 2'b10
    } tlb_state_e;

    localparam int         TGT_ITLB = 0;
    localparam int         TGT_DTLB = 1;
    localparam logic [1:0] TGT_NONE = 2'b00;
    localparam logic [1:0] TGT_BOTH = 2'b11;

    // A command completes immediately, with no RAM write, when it names no op or no TLB.
    function automatic logic is_noop(input tlb_op_e op, input logic [1:0] target);
        return (op == OP_NOP) || (target == TGT_NONE);
    endfunction

endpackage

// File: rtl/lm32_tlb_maint.sv
// TLB maintenance engine: serialises FLUSH / INVALIDATE / UPDATE commands into
// write strobes for the ITLB and DTLB RAMs, and flushes both TLBs out of reset.
module lm32_tlb_maint
    import lm32_tlb_maint_pkg::*;
#(
    parameter int tlb_sets  = 1024,
    parameter int page_size = 4096,
    localparam int IW = $clog2(tlb_sets),
    localparam int OW = $clog2(page_size),
    localparam int PW = 32 - OW,
    localparam int TW = PW - IW,
    localparam int WW = 1 + TW + PW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [1:0]    cmd_target,
    input  logic [31:0]   cmd_vaddr,
    input  logic [31:0]   cmd_paddr,
    input  logic          kernel_mode,
    output logic          itlb_we,
    output logic          dtlb_we,
    output logic [IW-1:0] tlb_waddr,
    output logic [WW-1:0] tlb_wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    tlb_state_e    r_state;
    logic [IW-1:0] r_cnt;
    logic          r_last;
    logic [1:0]    r_tgt;
    logic          r_itlb_we;
    logic          r_dtlb_we;
    logic [IW-1:0] r_waddr;
    logic [WW-1:0] r_wdata;
    logic          r_done;
    logic          r_err;

    tlb_op_e       w_op;
    logic          w_accept;
    logic          w_unused;

    assign w_op      = tlb_op_e'(cmd_op);
    assign w_accept  = cmd_valid && (r_state == ST_IDLE);
    assign w_unused  = ^{cmd_vaddr[OW-1:0], cmd_paddr[OW-1:0]};

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign itlb_we   = r_itlb_we;
    assign dtlb_we   = r_dtlb_we;
    assign tlb_waddr = r_waddr;
    assign tlb_wdata = r_wdata;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Reset always restarts a full flush of both TLBs from the top index.
            r_state   <= ST_FLUSH;
            r_cnt     <= IW'(tlb_sets - 1);
            r_last    <= 1'b0;
            r_tgt     <= TGT_BOTH;
            r_itlb_we <= 1'b0;
            r_dtlb_we <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_itlb_we <= 1'b0;
                    r_dtlb_we <= 1'b0;
                    if (w_accept) begin
                        if (w_op != OP_NOP && !kernel_mode) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else if (is_noop(w_op, cmd_target)) begin
                            r_done <= 1'b1;
                        end else if (w_op == OP_FLUSH) begin
                            r_state <= ST_FLUSH;
                            r_cnt   <= IW'(tlb_sets - 1);
                            r_last  <= 1'b0;
                            r_tgt   <= cmd_target;
                        end else begin
                            // Single-entry write is launched straight from the accept edge.
                            r_state   <= ST_WRITE;
                            r_itlb_we <= cmd_target[TGT_ITLB];
                            r_dtlb_we <= cmd_target[TGT_DTLB];
                            r_waddr   <= cmd_vaddr[OW+IW-1:OW];
                            r_wdata   <= (w_op == OP_UPDATE) ?
                                         {1'b1, cmd_vaddr[31:OW+IW], cmd_paddr[31:OW]} : '0;
                        end
                    end
                end
                ST_WRITE: begin
                    r_state   <= ST_IDLE;
                    r_itlb_we <= 1'b0;
                    r_dtlb_we <= 1'b0;
                    r_waddr   <= '0;
                    r_wdata   <= '0;
                    r_done    <= 1'b1;
                end
                ST_FLUSH: begin
                    r_wdata <= '0;
                    if (!r_last) begin
                        r_itlb_we <= r_tgt[TGT_ITLB];
                        r_dtlb_we <= r_tgt[TGT_DTLB];
                        r_waddr   <= r_cnt;
                        if (r_cnt == '0) r_last <= 1'b1;
                        else             r_cnt  <= r_cnt - 1'b1;
                    end else begin
                        // Index 0 was written last cycle; finish without wrapping.
                        r_state   <= ST_IDLE;
                        r_itlb_we <= 1'b0;
                        r_dtlb_we <= 1'b0;
                        r_waddr   <= '0;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_itlb_we <= 1'b0;
                    r_dtlb_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
